// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, frame FSM, FWFT byte FIFO, optional PS2_RX_KEYDECODE_EN decoder.
// Latency: byte/error/strobe visible one clk_sys cycle after the filtered stop-bit fall.
// Backpressure: rx_valid/rx_ready pop; a good byte arriving at a full FIFO is dropped and sets sticky overflow.
`timescale 1ns/1ps
module ps2_kbd_rx #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2048,
    parameter int FIFO_BITS  = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_pressed,
    output logic       key_extended
);
    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int CW    = FIFO_BITS + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered level only follows the synchronised clock after FILTER_LEN equal samples.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          par_ok;
    logic          push;

    assign par_ok = ^{shreg, par_bit};
    assign push   = fall && (state == STOP) && dat_s2 && par_ok;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE) begin
                if (fall && !dat_s2) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tmo_cnt <= TW'(1);
                end
            end else if (fall) begin
                tmo_cnt <= TW'(1);
                case (state)
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        // A bad stop bit masks a parity error.
                        if (!dat_s2)
                            frame_err <= 1'b1;
                        else if (!par_ok)
                            parity_err <= 1'b1;
                    end
                endcase
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    logic [7:0]           mem [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, do_pop, do_wr;

    assign full     = (count == CW'(DEPTH));
    assign rx_valid = (count != '0);
    assign do_pop   = rx_valid && rx_ready;
    assign do_wr    = push && (!full || do_pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk_sys) begin
        if (do_wr)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + FIFO_BITS'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + FIFO_BITS'(1);
            case ({do_wr, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !do_wr)
                overflow <= 1'b1;
        end
    end

`ifdef PS2_RX_KEYDECODE_EN
    logic ext_flag, brk_flag;

    // Taps every good frame, including ones the full FIFO drops.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            key_strobe   <= 1'b0;
            key_code     <= 8'h00;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (push) begin
                if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    key_code     <= shreg;
                    key_extended <= ext_flag;
                    key_pressed  <= ~brk_flag;
                    key_strobe   <= 1'b1;
                    ext_flag     <= 1'b0;
                    brk_flag     <= 1'b0;
                end
            end
        end
    end
`else
    assign key_strobe   = 1'b0;
    assign key_code     = 8'h00;
    assign key_pressed  = 1'b0;
    assign key_extended = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: PS/2 BFM, queue-based reference model compared every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 2048;
    localparam int FIFO_BITS  = 3;
    localparam int DEPTH      = 8;
    localparam int HALF       = 101;
    localparam int GAP        = 60;
    // Cycles from driving the stop-bit fall to the result being visible: 2 sync + filter + fall detect + register.
    localparam int LAT_END    = FILTER_LEN + 3;
    localparam int LAT_TMO    = LAT_END - 1 + TIMEOUT;
    localparam int EV_GOOD = 0, EV_PERR = 1, EV_FERR = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] b;
    } ev_t;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overflow;
    logic       key_strobe, key_pressed, key_extended;
    logic [7:0] key_code;

    always #5 clk_sys = ~clk_sys;

    ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .FIFO_BITS(FIFO_BITS)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
        .key_strobe(key_strobe), .key_code(key_code), .key_pressed(key_pressed),
        .key_extended(key_extended)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    int         cyc = 0;
    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ovf, m_strobe, m_perr, m_ferr, m_pressed, m_extd;
    logic [7:0] m_code;
`ifdef PS2_RX_KEYDECODE_EN
    bit         m_ext, m_brk;
`endif

    always @(posedge clk_sys) begin : model_cmp
        bit         pop, acc;
        logic [7:0] pb;
        ev_t        e;
        cyc = cyc + 1;
        m_strobe = 0;
        m_perr   = 0;
        m_ferr   = 0;
        acc      = 0;
        pb       = 8'h00;
        if (reset) begin
            mq.delete();
            evq.delete();
            m_ovf = 0; m_code = 8'h00; m_pressed = 0; m_extd = 0;
`ifdef PS2_RX_KEYDECODE_EN
            m_ext = 0; m_brk = 0;
`endif
        end else begin
            pop = rx_ready && (mq.size() > 0);
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                if (e.kind == EV_PERR) begin
                    m_perr = 1;
                end else if (e.kind == EV_FERR) begin
                    m_ferr = 1;
                end else begin
                    if (mq.size() < DEPTH || pop) begin
                        acc = 1;
                        pb  = e.b;
                    end else begin
                        m_ovf = 1;
                    end
`ifdef PS2_RX_KEYDECODE_EN
                    if (e.b == 8'hE0) m_ext = 1;
                    else if (e.b == 8'hF0) m_brk = 1;
                    else begin
                        m_code = e.b; m_extd = m_ext; m_pressed = !m_brk;
                        m_strobe = 1; m_ext = 0; m_brk = 0;
                    end
`endif
                end
            end
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(pb);
        end
        #1;
        check("cmp_rx_valid", int'(rx_valid), (mq.size() > 0) ? 1 : 0);
        check("cmp_rx_data", int'(rx_data), (mq.size() > 0) ? int'(mq[0]) : 0);
        check("cmp_parity_err", int'(parity_err), int'(m_perr));
        check("cmp_frame_err", int'(frame_err), int'(m_ferr));
        check("cmp_overflow", int'(overflow), int'(m_ovf));
        check("cmp_key_strobe", int'(key_strobe), int'(m_strobe));
        check("cmp_key_code", int'(key_code), int'(m_code));
        check("cmp_key_pressed", int'(key_pressed), int'(m_pressed));
        check("cmp_key_extended", int'(key_extended), int'(m_extd));
    end

    // Pulse/pop monitor for the literal checks
    int         perr_n = 0, ferr_n = 0, strobe_n = 0, ferr_cyc = 0, last_fall = 0;
    logic [7:0] last_pop = 8'h00;
    always @(negedge clk_sys) begin
        if (parity_err) perr_n++;
        if (frame_err) begin
            ferr_n++;
            ferr_cyc = cyc;
        end
        if (key_strobe) strobe_n++;
        if (rx_valid && rx_ready) last_pop = rx_data;
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nfalls);
        logic [10:0] bits;
        logic        p;
        ev_t         e;
        p = ~(^b);
        if (bad_par) p = ~p;
        bits = {~bad_stop, p, b, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            if (i == nfalls - 1) begin
                e.b = b;
                if (nfalls == 11) begin
                    e.cyc  = last_fall + LAT_END;
                    e.kind = bad_stop ? EV_FERR : (bad_par ? EV_PERR : EV_GOOD);
                end else begin
                    e.cyc  = last_fall + LAT_TMO;
                    e.kind = EV_FERR;
                end
                evq.push_back(e);
            end
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk_sys);
    endtask

    logic [7:0] got[$];
    task automatic drain();
        got.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            rx_ready = 1'b1;
            if (rx_valid) got.push_back(rx_data);
        end
        @(negedge clk_sys);
        rx_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int d_stop;
        repeat (4) @(negedge clk_sys);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_overflow", int'(overflow), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk_sys);

        // 1: single good byte
        send_frame(8'h1C, 0, 0, 11);
        check("t1_rx_valid", int'(rx_valid), 1);
        check("t1_rx_data", int'(rx_data), 'h1C);
        check("t1_no_perr", perr_n, 0);
        check("t1_no_ferr", ferr_n, 0);
`ifdef PS2_RX_KEYDECODE_EN
        check("t1_strobes", strobe_n, 1);
        check("t1_key_code", int'(key_code), 'h1C);
        check("t1_key_pressed", int'(key_pressed), 1);
        check("t1_key_extended", int'(key_extended), 0);
`else
        check("t1_strobes", strobe_n, 0);
`endif
        drain();
        check("t1_drain_n", got.size(), 1);

        // 2: extended break E0 F0 75
        strobe_n = 0;
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h75, 0, 0, 11);
`ifdef PS2_RX_KEYDECODE_EN
        check("t2_strobes", strobe_n, 1);
        check("t2_key_code", int'(key_code), 'h75);
        check("t2_key_pressed", int'(key_pressed), 0);
        check("t2_key_extended", int'(key_extended), 1);
`else
        check("t2_strobes", strobe_n, 0);
`endif
        drain();
        check("t2_drain_n", got.size(), 3);
        check("t2_drain_0", int'(got[0]), 'hE0);
        check("t2_drain_1", int'(got[1]), 'hF0);
        check("t2_drain_2", int'(got[2]), 'h75);

        // 3: parity error, stop error, then recovery
        rx_ready = 1'b1;
        perr_n = 0; ferr_n = 0;
        send_frame(8'h1C, 1, 0, 11);
        check("t3_perr_n", perr_n, 1);
        check("t3_perr_no_valid", int'(rx_valid), 0);
        send_frame(8'h1C, 0, 1, 11);
        check("t3_ferr_n", ferr_n, 1);
        check("t3_perr_still", perr_n, 1);
        d_stop = ferr_cyc - last_fall;
        send_frame(8'h32, 0, 0, 11);
        check("t3_recover", int'(last_pop), 'h32);

        // 4: timeout after 4 data bits
        ferr_n = 0;
        send_frame(8'hA5, 0, 0, 5);
        repeat (TIMEOUT + 100) @(negedge clk_sys);
        check("t4_ferr_n", ferr_n, 1);
        check("t4_timeout_vs_stop_delay", (ferr_cyc - last_fall) - d_stop, TIMEOUT - 1);
        send_frame(8'h4B, 0, 0, 11);
        check("t4_recover", int'(last_pop), 'h4B);

        // 5: overflow
        rx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 11);
        check("t5_overflow", int'(overflow), 1);
        check("t5_head", int'(rx_data), 'h01);
        drain();
        check("t5_drain_n", got.size(), 8);
        for (int i = 0; i < 8; i++) check("t5_drain_byte", int'(got[i]), i + 1);
        check("t5_empty", int'(rx_valid), 0);
        check("t5_overflow_sticky", int'(overflow), 1);

        // 6: idle glitches, then reset mid-frame
        rx_ready = 1'b1;
        perr_n = 0; ferr_n = 0;
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk_sys);
            ps2_clk = 1'b1;
            repeat (20) @(negedge clk_sys);
        end
        send_frame(8'h66, 0, 0, 11);
        check("t6_glitch_ok", int'(last_pop), 'h66);
        check("t6_glitch_perr", perr_n, 0);
        check("t6_glitch_ferr", ferr_n, 0);
        send_frame(8'h5A, 0, 0, 5);
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("t6_rst_overflow", int'(overflow), 0);
        check("t6_rst_rx_valid", int'(rx_valid), 0);
        check("t6_rst_key_code", int'(key_code), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk_sys);
        send_frame(8'h29, 0, 0, 11);
        check("t6_after_reset", int'(last_pop), 'h29);
        check("t6_no_ferr", ferr_n, 0);
        repeat (20) @(negedge clk_sys);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
